// File: rtl/bsg_cache_wbuf_ctrl_pkg.sv
// ----------------------------------------------------------------------
// bsg_cache_wbuf_ctrl_pkg : shared entry layout and controller states
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package bsg_cache_wbuf_ctrl_pkg;

  localparam int WBUF_ADDR_WIDTH = 32;
  localparam int WBUF_DATA_WIDTH = 32;

  // Layout of one buffered store; the controller repeats it at its own widths.
  typedef struct packed {
    logic [WBUF_ADDR_WIDTH-1:0] addr;
    logic [WBUF_DATA_WIDTH-1:0] data;
  } wbuf_entry_s;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } wbuf_state_e;

endpackage

`default_nettype wire

// File: rtl/bsg_cache_wbuf_ctrl_buffer_queue.sv
// ----------------------------------------------------------------------
// bsg_cache_buffer_queue : 2-entry queue with empty bypass and snoop taps
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module bsg_cache_buffer_queue #(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               el0_valid_o,
  output logic               el1_valid_o,
  output logic [width_p-1:0] el0_snoop_o,
  output logic [width_p-1:0] el1_snoop_o,
  output logic               empty_o,
  output logic               full_o
);

  logic [1:0]         count_r;
  logic [1:0]         count_n;
  logic [width_p-1:0] el0_r;
  logic [width_p-1:0] el1_r;

  always_comb begin
    count_n = count_r;
    if (v_i && !yumi_i) begin
      count_n = count_r + 2'd1;
    end else if (!v_i && yumi_i && (count_r != 2'd0)) begin
      count_n = count_r - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= 2'd0;
    end else begin
      count_r <= count_n;
    end
  end

  // el1 is always the oldest entry; el0 only holds the second one.
  always_ff @(posedge clk_i) begin
    case (count_r)
      2'd0: begin
        if (v_i && !yumi_i) el1_r <= data_i;
      end
      2'd1: begin
        if (v_i && yumi_i) el1_r <= data_i;
        else if (v_i)      el0_r <= data_i;
      end
      2'd2: begin
        if (yumi_i) el1_r <= el0_r;
      end
      default: begin
      end
    endcase
  end

  assign empty_o     = (count_r == 2'd0);
  assign full_o      = (count_r == 2'd2);
  assign el1_valid_o = !empty_o;
  assign el0_valid_o = full_o;
  assign el0_snoop_o = el0_r;
  assign el1_snoop_o = el1_r;
  assign v_o         = v_i || !empty_o;
  assign data_o      = empty_o ? data_i : el1_r;

endmodule

`default_nettype wire

// File: rtl/bsg_cache_wbuf_ctrl.sv
// ----------------------------------------------------------------------
// bsg_cache_wbuf_ctrl : two-requester store write buffer with flush/lookup
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module bsg_cache_wbuf_ctrl
  import bsg_cache_wbuf_ctrl_pkg::*;
#(
  parameter int addr_width_p = WBUF_ADDR_WIDTH,
  parameter int data_width_p = WBUF_DATA_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [1:0]                v_i,
  input  logic [2*addr_width_p-1:0] addr_i,
  input  logic [2*data_width_p-1:0] data_i,
  output logic [1:0]                yumi_o,
  output logic                      mem_v_o,
  output logic [addr_width_p-1:0]   mem_addr_o,
  output logic [data_width_p-1:0]   mem_data_o,
  input  logic                      mem_yumi_i,
  input  logic [addr_width_p-1:0]   lookup_addr_i,
  output logic                      lookup_hit_o,
  output logic [data_width_p-1:0]   lookup_data_o,
  input  logic                      flush_i,
  output logic                      flush_done_o,
  output logic                      empty_o
);

  localparam int entry_width_lp = addr_width_p + data_width_p;

  typedef struct packed {
    logic [addr_width_p-1:0] addr;
    logic [data_width_p-1:0] data;
  } entry_t;

  wbuf_state_e state_r;
  wbuf_state_e state_n;
  logic        last_r;
  logic [1:0]  grant;
  logic        flush_done;
  entry_t      grant_entry;
  entry_t      head_entry;
  entry_t      el0_entry;
  entry_t      el1_entry;
  logic        q_v;
  logic        q_yumi;
  logic        q_empty;
  logic        q_full;
  logic        el0_valid;
  logic        el1_valid;
  logic        hit0;
  logic        hit1;

  // last_r names the previous winner; a tie goes to the other requester.
  always_comb begin
    grant = 2'b00;
    if (!reset_i && (state_r == RUN) && !flush_i && !q_full) begin
      case (v_i)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_r ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    grant_entry.addr = grant[1] ? addr_i[2*addr_width_p-1:addr_width_p] : addr_i[addr_width_p-1:0];
    grant_entry.data = grant[1] ? data_i[2*data_width_p-1:data_width_p] : data_i[data_width_p-1:0];
  end

  always_comb begin
    state_n    = state_r;
    flush_done = 1'b0;
    case (state_r)
      RUN: begin
        if (flush_i) state_n = FLUSH;
      end
      FLUSH: begin
        if (q_empty) begin
          state_n    = RUN;
          flush_done = 1'b1;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= RUN;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_n;
      if (|grant) last_r <= grant[1];
    end
  end

  bsg_cache_buffer_queue #(
    .width_p (entry_width_lp)
  ) queue (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (|grant),
    .data_i      (grant_entry),
    .yumi_i      (q_yumi),
    .v_o         (q_v),
    .data_o      (head_entry),
    .el0_valid_o (el0_valid),
    .el1_valid_o (el1_valid),
    .el0_snoop_o (el0_entry),
    .el1_snoop_o (el1_entry),
    .empty_o     (q_empty),
    .full_o      (q_full)
  );

  // A stray yumi with nothing on offer must never pop the queue.
  assign q_yumi = mem_yumi_i && mem_v_o;

  assign hit0 = el0_valid && (el0_entry.addr == lookup_addr_i);
  assign hit1 = el1_valid && (el1_entry.addr == lookup_addr_i);

  assign yumi_o        = grant;
  assign mem_v_o       = q_v && !reset_i;
  assign mem_addr_o    = head_entry.addr;
  assign mem_data_o    = head_entry.data;
  assign lookup_hit_o  = (hit0 || hit1) && !reset_i;
  assign lookup_data_o = hit0 ? el0_entry.data : (hit1 ? el1_entry.data : '0);
  assign flush_done_o  = flush_done && !reset_i;
  assign empty_o       = q_empty || reset_i;

  assert property (@(posedge clk_i) disable iff (reset_i) mem_yumi_i |-> mem_v_o);

endmodule

`default_nettype wire

// File: tb/tb_bsg_cache_wbuf_ctrl.sv
// ----------------------------------------------------------------------
// tb_bsg_cache_wbuf_ctrl : directed and random checks against a queue model
// rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_bsg_cache_wbuf_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [1:0]      v_i;
  logic [2*AW-1:0] addr_i;
  logic [2*DW-1:0] data_i;
  logic [1:0]      yumi_o;
  logic            mem_v_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_data_o;
  logic            mem_yumi_i;
  logic [AW-1:0]   lookup_addr_i;
  logic            lookup_hit_o;
  logic [DW-1:0]   lookup_data_o;
  logic            flush_i;
  logic            flush_done_o;
  logic            empty_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bsg_cache_wbuf_ctrl #(.addr_width_p(AW), .data_width_p(DW)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .addr_i(addr_i), .data_i(data_i),
    .yumi_o(yumi_o), .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_yumi_i(mem_yumi_i), .lookup_addr_i(lookup_addr_i), .lookup_hit_o(lookup_hit_o),
    .lookup_data_o(lookup_data_o), .flush_i(flush_i), .flush_done_o(flush_done_o),
    .empty_o(empty_o)
  );

  // Reference model: FIFO of stores, previous winner, flushing flag.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t mq[$];
  int   last_w = 1;
  bit   fl = 1'b0;

  logic [1:0]    e_yumi;
  logic          e_mv, e_hit, e_fd, e_empty;
  logic [AW-1:0] e_maddr, e_gaddr;
  logic [DW-1:0] e_mdata, e_ldata, e_gdata;
  int            e_w;

  function automatic void predict();
    int sz;
    bit allow;
    sz = mq.size();
    e_yumi = 2'b00; e_mv = 1'b0; e_hit = 1'b0; e_fd = 1'b0; e_w = -1;
    e_maddr = '0; e_mdata = '0; e_ldata = '0; e_gaddr = '0; e_gdata = '0;
    if (reset_i) begin
      e_empty = 1'b1;
      return;
    end
    e_empty = (sz == 0);
    allow = !fl && !flush_i && (sz < 2);
    if (allow) begin
      if (v_i == 2'b01) e_w = 0;
      else if (v_i == 2'b10) e_w = 1;
      else if (v_i == 2'b11) e_w = (last_w == 1) ? 0 : 1;
    end
    if (e_w >= 0) begin
      e_yumi[e_w] = 1'b1;
      e_gaddr = addr_i[e_w*AW +: AW];
      e_gdata = data_i[e_w*DW +: DW];
    end
    e_mv = (sz > 0) || (e_w >= 0);
    if (sz > 0) begin
      e_maddr = mq[0].a; e_mdata = mq[0].d;
    end else begin
      e_maddr = e_gaddr; e_mdata = e_gdata;
    end
    for (int i = sz - 1; i >= 0; i--) begin
      if (mq[i].a == lookup_addr_i) begin
        e_hit = 1'b1; e_ldata = mq[i].d;
        break;
      end
    end
    e_fd = fl && (sz == 0);
  endfunction

  task automatic advance();
    int  sz;
    bit  bypassed;
    ent_t ne;
    predict();
    @(posedge clk);
    if (reset_i) begin
      mq.delete(); last_w = 1; fl = 1'b0;
    end else begin
      sz = mq.size();
      bypassed = 1'b0;
      if (mem_yumi_i && e_mv) begin
        if (sz > 0) void'(mq.pop_front());
        else bypassed = 1'b1;
      end
      if (e_w >= 0) begin
        ne.a = e_gaddr; ne.d = e_gdata;
        if (!bypassed) mq.push_back(ne);
        last_w = e_w;
      end
      if (!fl && flush_i) fl = 1'b1;
      else if (fl && sz == 0) fl = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    v_i = 2'b00; addr_i = '0; data_i = '0; mem_yumi_i = 1'b0;
    flush_i = 1'b0; lookup_addr_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    advance();
    advance();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b1;
    v_i = 2'b11;
    advance();
    @(negedge clk);
    checks++;
    if (yumi_o !== 2'b00 || mem_v_o !== 1'b0 || lookup_hit_o !== 1'b0 ||
        flush_done_o !== 1'b0 || empty_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: got yumi=%b mv=%b hit=%b fd=%b empty=%b expected 00 0 0 0 1",
               yumi_o, mem_v_o, lookup_hit_o, flush_done_o, empty_o);
    end
    v_i = 2'b00;
    advance();
    reset_i = 1'b0;
    @(negedge clk);
    checks++;
    if (empty_o !== 1'b1 || mem_v_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: got empty=%b mv=%b expected 1 0", empty_o, mem_v_o);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    v_i = 2'b01; addr_i = {32'h0, 32'h100}; data_i = {32'h0, 32'hA}; mem_yumi_i = 1'b1;
    @(negedge clk);
    checks++;
    if (yumi_o !== 2'b01 || mem_v_o !== 1'b1 || mem_addr_o !== 32'h100 ||
        mem_data_o !== 32'hA || empty_o !== 1'b1) begin
      failures++;
      $display("FAIL bypass: got yumi=%b mv=%b addr=%h data=%h empty=%b expected 01 1 100 a 1",
               yumi_o, mem_v_o, mem_addr_o, mem_data_o, empty_o);
    end
    advance();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (empty_o !== 1'b1 || mem_v_o !== 1'b0) begin
      failures++;
      $display("FAIL bypass_not_stored: got empty=%b mv=%b expected 1 0", empty_o, mem_v_o);
    end
    advance();
  endtask

  task automatic test_fill_fairness();
    logic [1:0]    exp_g [3] = '{2'b01, 2'b10, 2'b00};
    logic [AW-1:0] exp_a [2] = '{32'h10, 32'h20};
    do_reset();
    v_i = 2'b11; addr_i = {32'h20, 32'h10}; data_i = {32'h2, 32'h1};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (yumi_o !== exp_g[c]) begin
        failures++;
        $display("FAIL fill_grant[%0d]: got %b expected %b", c, yumi_o, exp_g[c]);
      end
      advance();
    end
    idle_inputs();
    mem_yumi_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (mem_v_o !== 1'b1 || mem_addr_o !== exp_a[c]) begin
        failures++;
        $display("FAIL drain_order[%0d]: got v=%b addr=%h expected 1 %h", c, mem_v_o, mem_addr_o, exp_a[c]);
      end
      advance();
    end
    mem_yumi_i = 1'b0;
    @(negedge clk);
    checks++;
    if (empty_o !== 1'b1) begin
      failures++;
      $display("FAIL drain_empty: got %b expected 1", empty_o);
    end
  endtask

  task automatic test_lookup();
    do_reset();
    v_i = 2'b01; addr_i = {32'h0, 32'h200}; data_i = {32'h0, 32'h1};
    advance();
    data_i = {32'h0, 32'h2};
    advance();
    idle_inputs();
    lookup_addr_i = 32'h200;
    @(negedge clk);
    checks++;
    if (lookup_hit_o !== 1'b1 || lookup_data_o !== 32'h2) begin
      failures++;
      $display("FAIL lookup_newest: got hit=%b data=%h expected 1 2", lookup_hit_o, lookup_data_o);
    end
    lookup_addr_i = 32'h204;
    @(negedge clk);
    checks++;
    if (lookup_hit_o !== 1'b0) begin
      failures++;
      $display("FAIL lookup_miss: got hit=%b expected 0", lookup_hit_o);
    end
    lookup_addr_i = 32'h200;
    mem_yumi_i = 1'b1;
    advance();
    mem_yumi_i = 1'b0;
    @(negedge clk);
    checks++;
    if (lookup_hit_o !== 1'b1 || lookup_data_o !== 32'h2) begin
      failures++;
      $display("FAIL lookup_single: got hit=%b data=%h expected 1 2", lookup_hit_o, lookup_data_o);
    end
  endtask

  task automatic test_flush();
    logic [1:0] exp_g  [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    logic       exp_fd [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       myumi  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    v_i = 2'b11; addr_i = {32'h44, 32'h40}; data_i = {32'h7, 32'h6};
    advance();
    advance();
    for (int c = 0; c < 7; c++) begin
      flush_i = (c == 0);
      mem_yumi_i = myumi[c];
      @(negedge clk);
      checks++;
      if (yumi_o !== exp_g[c] || flush_done_o !== exp_fd[c]) begin
        failures++;
        $display("FAIL flush_cycle[%0d]: got yumi=%b fd=%b expected %b %b", c, yumi_o, flush_done_o, exp_g[c], exp_fd[c]);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_empty_flush();
    logic exp_fd [3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      flush_i = (c == 0);
      @(negedge clk);
      checks++;
      if (flush_done_o !== exp_fd[c] || empty_o !== 1'b1) begin
        failures++;
        $display("FAIL empty_flush[%0d]: got fd=%b empty=%b expected %b 1", c, flush_done_o, empty_o, exp_fd[c]);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    v_i = 2'b11; addr_i = {32'h84, 32'h80}; data_i = {32'h9, 32'h8};
    advance();
    advance();
    v_i = 2'b00; flush_i = 1'b1;
    advance();
    flush_i = 1'b0; reset_i = 1'b1;
    @(negedge clk);
    checks++;
    if (flush_done_o !== 1'b0 || empty_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_flush_during: got fd=%b empty=%b expected 0 1", flush_done_o, empty_o);
    end
    advance();
    reset_i = 1'b0;
    v_i = 2'b11;
    @(negedge clk);
    checks++;
    if (empty_o !== 1'b1 || flush_done_o !== 1'b0 || yumi_o !== 2'b01) begin
      failures++;
      $display("FAIL reset_mid_flush_after: got empty=%b fd=%b yumi=%b expected 1 0 01", empty_o, flush_done_o, yumi_o);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset_i       = ($urandom_range(0, 99) == 0);
      v_i           = 2'($urandom_range(0, 3));
      addr_i        = {32'h400 + 32'($urandom_range(0, 3) << 2), 32'h400 + 32'($urandom_range(0, 3) << 2)};
      data_i        = {32'($urandom), 32'($urandom)};
      flush_i       = ($urandom_range(0, 15) == 0);
      lookup_addr_i = 32'h400 + 32'($urandom_range(0, 4) << 2);
      predict();
      mem_yumi_i    = e_mv && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      checks++;
      if (yumi_o !== e_yumi || mem_v_o !== e_mv || flush_done_o !== e_fd ||
          empty_o !== e_empty || lookup_hit_o !== e_hit) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: got yumi=%b mv=%b fd=%b empty=%b hit=%b expected %b %b %b %b %b",
                 c, yumi_o, mem_v_o, flush_done_o, empty_o, lookup_hit_o, e_yumi, e_mv, e_fd, e_empty, e_hit);
      end
      if (e_mv) begin
        checks++;
        if (mem_addr_o !== e_maddr || mem_data_o !== e_mdata) begin
          failures++;
          $display("FAIL rand_head[%0d]: got %h/%h expected %h/%h", c, mem_addr_o, mem_data_o, e_maddr, e_mdata);
        end
      end
      if (e_hit) begin
        checks++;
        if (lookup_data_o !== e_ldata) begin
          failures++;
          $display("FAIL rand_lookup[%0d]: got %h expected %h", c, lookup_data_o, e_ldata);
        end
      end
      advance();
    end
    idle_inputs();
    reset_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset_i = 1'b1;
    test_reset();
    test_bypass();
    test_fill_fairness();
    test_lookup();
    test_flush();
    test_empty_flush();
    test_reset_mid_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
